// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Instruction fetch sequencer. Issues one fetch at a time to the
//               instruction memory, hands the returned word to decode, and
//               holds it until decode accepts it. It then computes the next
//               PC (JALR > JAL > taken branch > +4). A target with bit 1 set
//               is misaligned: it diverts the PC to TRAP_VEC and pulses
//               misalign_err.
// Ports       : clock, reset (async, active-high)
//               stall                     - decode not ready, hold instruction
//               br_en/br_taken/jal_en/jalr_en, imm_b/imm_j/jalr_tgt
//                                         - redirect info for held instruction
//               imem_req/imem_addr        - fetch request and address
//               imem_ready/imem_valid/imem_rdata - memory handshake/response
//               inst_valid/inst/inst_pc   - instruction to decode
//               pc, pc_sel, jlr_sel       - architectural PC and select codes
//               misalign_err              - one-cycle misaligned-redirect pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_en,
    input  logic        br_taken,
    input  logic        jal_en,
    input  logic        jalr_en,
    input  logic [31:0] imm_b,
    input  logic [31:0] imm_j,
    input  logic [31:0] jalr_tgt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic        jlr_sel,
    output logic        misalign_err
);

    localparam logic [31:0] c_PC_STEP  = 32'd4;
    localparam logic [31:0] c_JALR_MSK = 32'hFFFF_FFFE;

    localparam logic [1:0] c_SEL_SEQ = 2'd0;
    localparam logic [1:0] c_SEL_JAL = 2'd1;
    localparam logic [1:0] c_SEL_BR  = 2'd2;
    localparam logic [1:0] c_SEL_RST = 2'd3;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_imem_req;
    logic        w_capture;
    logic        w_advance;

    logic [31:0] r_pc;
    logic [1:0]  r_pc_sel;
    logic        r_jlr_sel;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    logic        r_misalign;

    logic [31:0] w_target;
    logic [1:0]  w_sel;
    logic        w_jlr;
    logic        w_misalign;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control. Only one fetch is ever in flight: a new
    // request is raised only after the previous instruction left HOLD.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC selection, relative targets based on the held inst_pc.
    // ------------------------------------------------------------------
    always_comb begin
        w_target = r_inst_pc + c_PC_STEP;
        w_sel    = c_SEL_SEQ;
        w_jlr    = 1'b0;
        if (jalr_en) begin
            w_target = jalr_tgt & c_JALR_MSK;
            w_jlr    = 1'b1;
        end else if (jal_en) begin
            w_target = r_inst_pc + imm_j;
            w_sel    = c_SEL_JAL;
        end else if (br_en && br_taken) begin
            w_target = r_inst_pc + imm_b;
            w_sel    = c_SEL_BR;
        end
    end

    assign w_misalign = w_target[1];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_VEC;
            r_pc_sel     <= c_SEL_RST;
            r_jlr_sel    <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (w_capture) begin
                r_inst       <= imem_rdata;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
            end
            if (w_advance) begin
                r_inst_valid <= 1'b0;
                r_pc_sel     <= w_sel;
                r_jlr_sel    <= w_jlr;
                r_misalign   <= w_misalign;
                r_pc         <= w_misalign ? TRAP_VEC : w_target;
            end
        end
    end

    assign imem_req     = w_imem_req;
    assign imem_addr    = r_pc;
    assign inst_valid   = r_inst_valid;
    assign inst         = r_inst;
    assign inst_pc      = r_inst_pc;
    assign pc           = r_pc;
    assign pc_sel       = r_pc_sel;
    assign jlr_sel      = r_jlr_sel;
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Acts as instruction
//               memory and decode, and predicts the PC sequence from the
//               next-PC rules with plain 32-bit arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, br_en, br_taken, jal_en, jalr_en;
    logic [31:0] imm_b, imm_j, jalr_tgt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_valid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst, inst_pc, pc;
    logic [1:0]  pc_sel;
    logic        jlr_sel, misalign_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] cur_word;

    pc_sequencer #(.RESET_VEC(RV), .TRAP_VEC(TV)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .br_en(br_en), .br_taken(br_taken), .jal_en(jal_en), .jalr_en(jalr_en),
        .imm_b(imm_b), .imm_j(imm_j), .jalr_tgt(jalr_tgt),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc(pc),
        .pc_sel(pc_sel), .jlr_sel(jlr_sel), .misalign_err(misalign_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_redir();
        br_en    = 1'($urandom_range(0, 1));
        br_taken = 1'($urandom_range(0, 1));
        jal_en   = 1'($urandom_range(0, 1));
        jalr_en  = 1'($urandom_range(0, 1));
        imm_b    = $urandom;
        imm_j    = $urandom;
        jalr_tgt = $urandom;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, RV);
        chk({tag, "_pc_sel"}, 32'(pc_sel), 32'd3);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_ivalid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_mis"}, 32'(misalign_err), 32'd0);
        chk({tag, "_jlr"}, 32'(jlr_sel), 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    // One fetch: entered just after the edge that put the DUT in REQ.
    task automatic fetch(input logic [31:0] word, input int rdly, input int vdly);
        cur_word = word;
        chk("req_in_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < rdly; i++) begin
            imem_ready = 1'b0;
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            stall      = 1'($urandom_range(0, 1));
            rand_redir();
            step();
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, exp_pc);
            chk("ivalid_in_req", 32'(inst_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        step();
        chk("req_low_wait", 32'(imem_req), 32'd0);
        chk("mis_cleared", 32'(misalign_err), 32'd0);
        chk("pc_in_wait", pc, exp_pc);
        for (int i = 0; i < vdly; i++) begin
            imem_valid = 1'b0;
            imem_ready = 1'($urandom_range(0, 1));
            stall      = 1'($urandom_range(0, 1));
            rand_redir();
            step();
            chk("req_low_wait2", 32'(imem_req), 32'd0);
            chk("ivalid_in_wait", 32'(inst_valid), 32'd0);
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        imem_ready = 1'($urandom_range(0, 1));
        step();
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        chk("ivalid_set", 32'(inst_valid), 32'd1);
        chk("inst_captured", inst, word);
        chk("inst_pc_captured", inst_pc, exp_pc);
        chk("req_low_hold", 32'(imem_req), 32'd0);
    endtask

    // Hold with nstall stalled cycles, then release with the given redirect.
    task automatic hold(input int nstall, input logic jr, input logic j,
                        input logic b, input logic t, input logic [31:0] ib,
                        input logic [31:0] ij, input logic [31:0] jt);
        logic [31:0] ipc, tgt;
        logic [1:0]  esel;
        logic        ejlr, emis;
        for (int i = 0; i < nstall; i++) begin
            stall      = 1'b1;
            imem_ready = 1'($urandom_range(0, 1));
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            rand_redir();
            step();
            chk("stall_inst", inst, cur_word);
            chk("stall_inst_pc", inst_pc, exp_pc);
            chk("stall_ivalid", 32'(inst_valid), 32'd1);
            chk("stall_no_req", 32'(imem_req), 32'd0);
            chk("stall_pc", pc, exp_pc);
        end
        ipc  = exp_pc;
        ejlr = 1'b0;
        if (jr) begin
            tgt  = {jt[31:1], 1'b0};
            esel = 2'd0;
            ejlr = 1'b1;
        end else if (j) begin
            tgt  = 32'((64'(ipc) + 64'(ij)) % 64'h1_0000_0000);
            esel = 2'd1;
        end else if (b && t) begin
            tgt  = 32'((64'(ipc) + 64'(ib)) % 64'h1_0000_0000);
            esel = 2'd2;
        end else begin
            tgt  = 32'((64'(ipc) + 64'd4) % 64'h1_0000_0000);
            esel = 2'd0;
        end
        emis   = tgt[1];
        exp_pc = emis ? TV : tgt;
        stall = 1'b0;
        jalr_en = jr; jal_en = j; br_en = b; br_taken = t;
        imm_b = ib; imm_j = ij; jalr_tgt = jt;
        step();
        chk("next_pc", pc, exp_pc);
        chk("pc_sel", 32'(pc_sel), 32'(esel));
        chk("jlr_sel", 32'(jlr_sel), 32'(ejlr));
        chk("misalign_err", 32'(misalign_err), 32'(emis));
        chk("ivalid_clr", 32'(inst_valid), 32'd0);
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_addr", imem_addr, exp_pc);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        br_en = 1'b0; br_taken = 1'b0; jal_en = 1'b0; jalr_en = 1'b0;
        imm_b = '0; imm_j = '0; jalr_tgt = '0;
        imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        exp_pc = RV; cur_word = '0;
        #2;
        chk_reset_vals("rst");
        step();
        step();
        reset      = 1'b0;
        imem_ready = 1'b1;
        chk("no_req_before_edge", 32'(imem_req), 32'd0);
        step();
        chk("first_req_pc_sel", 32'(pc_sel), 32'd3);

        // Straight-line fetches at 0, 4, 8; the third ends in a JAL to 0x100.
        fetch(32'h0000_0013, 0, 0);
        hold(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        fetch(32'h0000_0013, 0, 0);
        hold(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        fetch(32'h0000_0013, 0, 0);
        hold(0, 0, 1, 0, 0, 32'd0, 32'h0000_00F8, 32'd0);
        // Taken backward branch with 5 stalled cycles, 3 cycles of ready low.
        fetch(32'h1234_5678, 3, 1);
        hold(5, 0, 0, 1, 1, 32'hFFFF_FFF0, 32'd0, 32'd0);
        fetch(32'hCAFE_0001, 0, 2);
        hold(0, 0, 1, 0, 0, 32'd0, 32'h0000_0010, 32'd0);
        // Not-taken branch falls through to +4.
        fetch(32'h0BAD_F00D, 1, 0);
        hold(0, 0, 0, 1, 0, 32'hFFFF_FFF0, 32'd0, 32'd0);
        // JALR beats JAL; bit 0 cleared; then a misaligned JALR traps.
        fetch(32'h0000_0067, 0, 0);
        hold(1, 1, 1, 0, 0, 32'd0, 32'h0000_0040, 32'h0000_0201);
        fetch(32'h0000_0067, 0, 0);
        hold(0, 1, 0, 0, 0, 32'd0, 32'd0, 32'h0000_0202);
        // Wrap of +4 past the top of the address space.
        fetch(32'h0000_0067, 0, 0);
        hold(0, 1, 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 0, 0);
        hold(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            hold($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFE,
                 $urandom & 32'hFFFF_FFFE, $urandom);
        end

        // Reset in the middle of a fetch, then a late response.
        imem_ready = 1'b1;
        imem_valid = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        step();
        reset      = 1'b0;
        imem_ready = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("late_valid_ivalid", 32'(inst_valid), 32'd0);
        chk("late_valid_inst", inst, 32'd0);
        chk("late_valid_inst_pc", inst_pc, 32'd0);
        chk("late_valid_pc_sel", 32'(pc_sel), 32'd3);
        step();
        chk("late_valid_ivalid2", 32'(inst_valid), 32'd0);
        exp_pc = RV;
        fetch(32'h0000_0093, 0, 1);
        hold(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
